// File: rtl/rs_enc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rs_enc_ctrl
//  Description : Sequencer for the stage-chained RS(N,K) GF(2^8) systematic
//                encoder. Passes K message symbols straight through while
//                feeding (message ^ parity tail) to every parity stage, then
//                shifts out NPAR parity symbols with zero feedback.
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_enc_ctrl #(
  parameter int K     = 239,
  parameter int NPAR  = 16,
  parameter int SYM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [SYM_W-1:0] s_data_i,
  input  logic             s_last_i,
  input  logic [SYM_W-1:0] par_tail_i,
  output logic [SYM_W-1:0] fb_sym_o,
  output logic             lfsr_en_o,
  output logic             par_clr_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [SYM_W-1:0] m_data_o,
  output logic             m_sop_o,
  output logic             m_last_o,
  output logic             busy_o,
  output logic             len_err_o
);

  localparam int MSG_W = (K > 1) ? $clog2(K) : 1;
  localparam int PAR_W = (NPAR > 1) ? $clog2(NPAR) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MSG  = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MSG_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic [PAR_W-1:0]   par_cnt_q, par_cnt_d;
  logic               par_clr_q;
  logic               len_err_q, len_err_d;

  logic               w_live;
  logic               w_in_msg;
  logic               w_acc;
  logic               w_cnt_last;
  logic               w_par_last;

  // While the parity stages are being cleared the controller stays silent,
  // so no symbol can be absorbed into registers that are being wiped.
  assign w_live     = ~par_clr_q;
  assign w_in_msg   = (state_q == S_IDLE) || (state_q == S_MSG);
  assign s_ready_o  = w_live & w_in_msg & m_ready_i;
  assign w_acc      = s_valid_i & s_ready_o;
  assign w_cnt_last = (msg_cnt_q == MSG_W'(K - 1));
  assign w_par_last = (par_cnt_q == PAR_W'(NPAR - 1));

  assign par_clr_o  = par_clr_q;
  assign len_err_o  = len_err_q;
  assign busy_o     = (state_q != S_IDLE);

  // Next-state, counters and all handshake/datapath controls
  always_comb begin
    state_d   = state_q;
    msg_cnt_d = msg_cnt_q;
    par_cnt_d = par_cnt_q;
    len_err_d = 1'b0;
    m_valid_o = 1'b0;
    m_data_o  = '0;
    m_sop_o   = 1'b0;
    m_last_o  = 1'b0;
    lfsr_en_o = 1'b0;
    fb_sym_o  = '0;
    case (state_q)
      S_IDLE, S_MSG: begin
        if (w_live) begin
          m_valid_o = s_valid_i;
          m_data_o  = s_data_i;
          m_sop_o   = (state_q == S_IDLE);
          if (w_acc) begin
            lfsr_en_o = 1'b1;
            fb_sym_o  = s_data_i ^ par_tail_i;
            // Either end marker closes the message; a disagreement between
            // s_last and the count is flagged but the frame still closes.
            if (s_last_i || w_cnt_last) begin
              state_d   = S_PAR;
              msg_cnt_d = '0;
              par_cnt_d = '0;
              len_err_d = (s_last_i != w_cnt_last);
            end else begin
              state_d   = S_MSG;
              msg_cnt_d = msg_cnt_q + MSG_W'(1);
            end
          end
        end
      end
      S_PAR: begin
        m_valid_o = 1'b1;
        m_data_o  = par_tail_i;
        m_last_o  = w_par_last;
        if (m_ready_i) begin
          // Zero feedback turns the stage chain into a plain shift register.
          lfsr_en_o = 1'b1;
          if (w_par_last) begin
            state_d   = S_IDLE;
            par_cnt_d = '0;
          end else begin
            par_cnt_d = par_cnt_q + PAR_W'(1);
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        msg_cnt_d = '0;
        par_cnt_d = '0;
      end
    endcase
  end

  // State and counter registers; reset abandons any frame and clears stages
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      msg_cnt_q <= '0;
      par_cnt_q <= '0;
      par_clr_q <= 1'b1;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      msg_cnt_q <= msg_cnt_d;
      par_cnt_q <= par_cnt_d;
      par_clr_q <= 1'b0;
      len_err_q <= len_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rs_enc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_enc_ctrl
//  Description : Self-checking bench for rs_enc_ctrl with a GF(2^8) parity
//                stage chain around it and a polynomial-division RS model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_enc_ctrl;

  localparam int K    = 239;
  localparam int NPAR = 16;

  typedef logic [7:0] byteq_t[$];

  typedef struct {
    int nsym;
    bit mark_last;
    int pat;
    int vpct;
    int rpct;
    int exp_err;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid, s_ready, s_last;
  logic [7:0] s_data, par_tail, fb_sym, m_data;
  logic       lfsr_en, par_clr, m_valid, m_ready, m_sop, m_last, busy, len_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] gpoly [0:NPAR];
  logic [7:0] stg   [0:NPAR-1];

  always #5 clk = ~clk;

  rs_enc_ctrl #(.K(K), .NPAR(NPAR), .SYM_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid_i  (s_valid),
    .s_ready_o  (s_ready),
    .s_data_i   (s_data),
    .s_last_i   (s_last),
    .par_tail_i (par_tail),
    .fb_sym_o   (fb_sym),
    .lfsr_en_o  (lfsr_en),
    .par_clr_o  (par_clr),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_sop_o    (m_sop),
    .m_last_o   (m_last),
    .busy_o     (busy),
    .len_err_o  (len_err)
  );

  // GF(2^8) multiply, primitive polynomial x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  // Parity stage chain the controller sequences (environment datapath)
  assign par_tail = stg[NPAR-1];
  always @(posedge clk) begin
    if (par_clr) begin
      for (int j = 0; j < NPAR; j++) stg[j] <= 8'h00;
    end else if (lfsr_en) begin
      for (int j = NPAR - 1; j > 0; j--) stg[j] <= stg[j-1] ^ gmul(fb_sym, gpoly[j]);
      stg[0] <= gmul(fb_sym, gpoly[0]);
    end
  end

  // Reference codeword: message followed by remainder of m(x)*x^NPAR / g(x)
  function automatic void ref_cw(input byteq_t msg, output byteq_t cw);
    byteq_t work;
    logic [7:0] c;
    work = msg;
    for (int i = 0; i < NPAR; i++) work.push_back(8'h00);
    for (int i = 0; i < msg.size(); i++) begin
      c = work[i];
      for (int j = 1; j <= NPAR; j++) work[i+j] = work[i+j] ^ gmul(c, gpoly[NPAR-j]);
    end
    cw = msg;
    for (int i = 0; i < NPAR; i++) cw.push_back(work[msg.size()+i]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    s_last  = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_par_clr", par_clr, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_sop",   m_sop,   0);
    chk("rst_m_last",  m_last,  0);
    chk("rst_busy",    busy,    0);
    chk("rst_lfsr_en", lfsr_en, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_fb_sym",  fb_sym,  0);
    chk("rst_m_data",  m_data,  0);
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_par_clr",  par_clr,  0);
    chk("post_rst_par_tail", par_tail, 0);
  endtask

  task automatic run_frame(input frame_t f);
    byteq_t msg, cw;
    int  idx = 0, oidx = 0, cyc = 0, n_lfsr = 0, n_lerr = 0, total;
    bit  pend = 1'b0, in_msg, acc, ev, hs;
    for (int i = 0; i < f.nsym; i++) begin
      case (f.pat)
        0:       msg.push_back(8'(i + 1));
        1:       msg.push_back(8'h00);
        default: msg.push_back(8'($urandom));
      endcase
    end
    ref_cw(msg, cw);
    total = f.nsym + NPAR;
    while (oidx < total && cyc < 4000) begin
      @(negedge clk);
      in_msg  = (idx < f.nsym);
      s_valid = in_msg ? ($urandom_range(99) < f.vpct) : 1'($urandom);
      s_data  = in_msg ? msg[idx] : 8'($urandom);
      s_last  = in_msg && f.mark_last && (idx == f.nsym - 1);
      m_ready = ($urandom_range(99) < f.rpct);
      #1;
      acc = in_msg && s_valid && m_ready;
      ev  = in_msg ? s_valid : 1'b1;
      hs  = ev && m_ready;
      chk("s_ready", s_ready, in_msg ? m_ready : 1'b0);
      chk("m_valid", m_valid, ev);
      chk("m_sop",   m_sop,   oidx == 0);
      chk("m_last",  m_last,  !in_msg && (oidx == total - 1));
      chk("busy",    busy,    idx > 0);
      chk("len_err", len_err, pend);
      chk("lfsr_en", lfsr_en, acc || (!in_msg && m_ready));
      chk("fb_sym",  fb_sym,  acc ? (s_data ^ par_tail) : 8'h00);
      if (ev) chk("m_data", m_data, cw[oidx]);
      n_lfsr += int'(lfsr_en);
      n_lerr += int'(len_err);
      pend = acc && (s_last != (idx == K - 1));
      if (acc) idx++;
      if (hs) oidx++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("frame_timeout", oidx, total);
    chk("lfsr_en_count", n_lfsr, total);
    chk("len_err_count", n_lerr, f.exp_err);
    if (f.vpct == 100 && f.rpct == 100) chk("no_bubble_cycles", cyc, total);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t     tbl[9];
    byteq_t     gmsg, gcw;
    logic [7:0] a;

    // Generator g(x) = prod_{i=0}^{NPAR-1} (x + alpha^i)
    for (int j = 0; j <= NPAR; j++) gpoly[j] = 8'h00;
    gpoly[0] = 8'h01;
    a = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--) gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], a);
      gpoly[0] = gmul(gpoly[0], a);
      a = gmul(a, 8'h02);
    end

    tbl[0] = '{nsym: 239, mark_last: 1, pat: 0, vpct: 100, rpct: 100, exp_err: 0};
    tbl[1] = '{nsym: 239, mark_last: 1, pat: 1, vpct: 100, rpct: 100, exp_err: 0};
    tbl[2] = '{nsym: 239, mark_last: 1, pat: 0, vpct: 50,  rpct: 50,  exp_err: 0};
    tbl[3] = '{nsym: 100, mark_last: 1, pat: 2, vpct: 100, rpct: 100, exp_err: 1};
    tbl[4] = '{nsym: 239, mark_last: 1, pat: 0, vpct: 100, rpct: 100, exp_err: 0};
    tbl[5] = '{nsym: 239, mark_last: 0, pat: 2, vpct: 70,  rpct: 60,  exp_err: 1};
    tbl[6] = '{nsym: 1,   mark_last: 1, pat: 2, vpct: 80,  rpct: 80,  exp_err: 1};
    tbl[7] = '{nsym: 238, mark_last: 1, pat: 2, vpct: 50,  rpct: 50,  exp_err: 1};
    tbl[8] = '{nsym: 239, mark_last: 1, pat: 2, vpct: 30,  rpct: 90,  exp_err: 0};

    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    do_reset();

    for (int t = 0; t < 9; t++) run_frame(tbl[t]);

    // Reset while parity symbol 5 of a golden frame is on the output
    for (int i = 0; i < K; i++) gmsg.push_back(8'(i + 1));
    ref_cw(gmsg, gcw);
    for (int i = 0; i < K + 5; i++) begin
      @(negedge clk);
      s_valid = (i < K);
      s_data  = 8'(i + 1);
      s_last  = (i == K - 1);
      m_ready = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk("abort_par5_data", m_data, gcw[K+5]);
    chk("abort_busy",      busy,   1);
    do_reset();
    run_frame(tbl[0]);

    // Two frames back to back with no idle cycle in between
    run_frame(tbl[4]);
    run_frame(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
